// File: rtl/fsm_eg_stim_driver.sv
// Stimulus driver and response checker for the two-segment example FSM.
// It keeps a shadow copy of the FSM state, drives a/b per command and counts y0/y1 mismatches.
module fsm_eg_stim_driver #(
    parameter int CNT_W = 8,
    parameter int RPT_W = 4
) (
    input  logic             clk_amisha,
    input  logic             reset_amisha,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [RPT_W-1:0] cmd_rpt,
    output logic             cmd_ready,
    output logic             a_out,
    output logic             b_out,
    input  logic             y0_in,
    input  logic             y1_in,
    input  logic             err_clr,
    output logic [1:0]       shadow_state,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_count,
    output logic             done,
    output logic             drive_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both 1;
    // cmd_ready is high only in IDLE and a command offered while busy is dropped, not buffered.
    typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} drv_state_t;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;

    localparam logic [1:0] OP_HOLD    = 2'b00;
    localparam logic [1:0] OP_STEP_A  = 2'b01;
    localparam logic [1:0] OP_STEP_AB = 2'b10;

    drv_state_t       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [RPT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d, b_q, b_d;
    logic             done_q, done_d;
    logic [1:0]       sh_q, sh_d, sh_nxt;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             exp_y0, exp_y1, mismatch;

    // Returns {a, b} for an op, given the shadow state the drive cycle will start in.
    function automatic logic [1:0] drive_ab(input logic [1:0] op, input logic [1:0] sh);
        case (op)
            OP_HOLD:    drive_ab = 2'b00;
            OP_STEP_A:  drive_ab = 2'b10;
            OP_STEP_AB: drive_ab = 2'b11;
            default:    drive_ab = (sh == S1) ? 2'b10 : 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            state_q <= IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            done_q  <= 1'b0;
            sh_q    <= S0;
            flag_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            sh_q    <= sh_d;
            flag_q  <= flag_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        done_d   = 1'b0;
        sh_d     = sh_q;
        flag_d   = flag_q;
        count_d  = count_q;
        mismatch = 1'b0;

        case (sh_q)
            S0:      sh_nxt = (a_q && b_q) ? S2 : (a_q ? S1 : S0);
            S1:      sh_nxt = a_q ? S0 : S1;
            default: sh_nxt = S0;
        endcase

        exp_y1 = (sh_q == S0) || (sh_q == S1);
        exp_y0 = (sh_q == S0) && a_q && b_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d    = DRIVE;
                    op_d       = cmd_op;
                    cnt_d      = cmd_rpt;
                    {a_d, b_d} = drive_ab(cmd_op, sh_q);
                end
            end
            default: begin
                mismatch = (y0_in != exp_y0) || (y1_in != exp_y1);
                sh_d     = sh_nxt;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end else begin
                    cnt_d      = cnt_q - RPT_W'(1);
                    {a_d, b_d} = drive_ab(op_q, sh_nxt);
                end
            end
        endcase

        // A clear coincident with a mismatch clears first, then counts that mismatch.
        if (err_clr) begin
            flag_d  = mismatch;
            count_d = mismatch ? CNT_W'(1) : '0;
        end else if (mismatch) begin
            flag_d = 1'b1;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign a_out        = a_q;
    assign b_out        = b_q;
    assign done         = done_q;
    assign shadow_state = sh_q;
    assign err_flag     = flag_q;
    assign err_count    = count_q;
    assign drive_state  = (state_q == DRIVE);

endmodule

// File: tb/tb_fsm_eg_stim_driver.sv
// Bench for fsm_eg_stim_driver: a behavioural example FSM answers the driver, and a
// done-triggered monitor compares each command's outcome against a queued expectation.
module tb_fsm_eg_stim_driver;

    localparam logic [1:0] OP_HOLD    = 2'b00;
    localparam logic [1:0] OP_STEP_A  = 2'b01;
    localparam logic [1:0] OP_STEP_AB = 2'b10;
    localparam logic [1:0] OP_RESYNC  = 2'b11;

    logic       clk_amisha = 1'b0;
    logic       reset_amisha;
    logic       cmd_valid, err_clr, force_y1_low;
    logic [1:0] cmd_op;
    logic [3:0] cmd_rpt;
    logic       cmd_ready, a_out, b_out, y0_in, y1_in, err_flag, done, drive_state;
    logic [1:0] shadow_state;
    logic [7:0] err_count;

    logic       cmd_valid2, err_clr2, cmd_ready2, a_out2, b_out2, err_flag2, done2, drive_state2;
    logic [1:0] cmd_op2, shadow_state2;
    logic [3:0] cmd_rpt2;
    logic [1:0] err_count2;
    logic       y0_in2, y1_in2;

    logic [1:0] fsm_st;
    logic [22:0] exp_q[$];
    int n_vec = 0;
    int n_miss = 0;
    logic [3:0] busy_cnt, a_cnt, b_cnt;

    always #5 clk_amisha = ~clk_amisha;

    fsm_eg_stim_driver #(.CNT_W(8), .RPT_W(4)) u_dut (
        .clk_amisha(clk_amisha), .reset_amisha(reset_amisha),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_rpt(cmd_rpt), .cmd_ready(cmd_ready),
        .a_out(a_out), .b_out(b_out), .y0_in(y0_in), .y1_in(y1_in), .err_clr(err_clr),
        .shadow_state(shadow_state), .err_flag(err_flag), .err_count(err_count),
        .done(done), .drive_state(drive_state)
    );

    fsm_eg_stim_driver #(.CNT_W(2), .RPT_W(4)) u_dut_sat (
        .clk_amisha(clk_amisha), .reset_amisha(reset_amisha),
        .cmd_valid(cmd_valid2), .cmd_op(cmd_op2), .cmd_rpt(cmd_rpt2), .cmd_ready(cmd_ready2),
        .a_out(a_out2), .b_out(b_out2), .y0_in(y0_in2), .y1_in(y1_in2), .err_clr(err_clr2),
        .shadow_state(shadow_state2), .err_flag(err_flag2), .err_count(err_count2),
        .done(done2), .drive_state(drive_state2)
    );

    // Example FSM the driver sits against: S0/S1/S2 with y1 in S0|S1 and y0 in S0 with a&b.
    always @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) fsm_st <= 2'b00;
        else begin
            case (fsm_st)
                2'b00:   fsm_st <= (a_out && b_out) ? 2'b10 : (a_out ? 2'b01 : 2'b00);
                2'b01:   fsm_st <= a_out ? 2'b00 : 2'b01;
                default: fsm_st <= 2'b00;
            endcase
        end
    end

    assign y0_in = (fsm_st == 2'b00) && a_out && b_out;
    assign y1_in = force_y1_low ? 1'b0 : (fsm_st != 2'b10);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [22:0] mk_exp(input logic [1:0] sh, input logic flag, input logic [7:0] cnt,
                                           input logic [3:0] busy, input logic [3:0] na, input logic [3:0] nb);
        return {sh, flag, cnt, busy, na, nb};
    endfunction

    // Tallies drive cycles while busy and checks the command outcome on done.
    always @(negedge clk_amisha) begin
        if (reset_amisha) begin
            busy_cnt = '0; a_cnt = '0; b_cnt = '0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                check("cmd_response", 32'({shadow_state, err_flag, err_count, busy_cnt, a_cnt, b_cnt}),
                      32'(exp_q.pop_front()));
            end
            busy_cnt = '0; a_cnt = '0; b_cnt = '0;
        end else if (!cmd_ready) begin
            busy_cnt = busy_cnt + 4'd1;
            a_cnt    = a_cnt + 4'(a_out);
            b_cnt    = b_cnt + 4'(b_out);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [3:0] rpt, input logic push, input logic [22:0] e);
        int t;
        t = 0;
        @(negedge clk_amisha);
        while (!cmd_ready && t < 50) begin
            @(negedge clk_amisha);
            t++;
        end
        if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
        if (push) exp_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rpt   = rpt;
        @(posedge clk_amisha);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(negedge clk_amisha);
        while (!done && t < 40) begin
            @(negedge clk_amisha);
            t++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk_amisha);
        reset_amisha = 1'b1;
        @(negedge clk_amisha);
        reset_amisha = 1'b0;
    endtask

    initial begin
        int t;
        reset_amisha = 1'b1;
        cmd_valid = 1'b0; cmd_op = OP_HOLD; cmd_rpt = '0; err_clr = 1'b0; force_y1_low = 1'b0;
        cmd_valid2 = 1'b0; cmd_op2 = OP_HOLD; cmd_rpt2 = '0; err_clr2 = 1'b0;
        y0_in2 = 1'b0; y1_in2 = 1'b0;
        repeat (2) @(negedge clk_amisha);
        check("rst_a_out", 32'(a_out), 32'd0);
        check("rst_b_out", 32'(b_out), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_shadow", 32'(shadow_state), 32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        reset_amisha = 1'b0;

        // STEP_AB rpt=0: one a=b=1 cycle, S0 -> S2.
        issue(OP_STEP_AB, 4'd0, 1'b1, mk_exp(2'd2, 1'b0, 8'd0, 4'd1, 4'd1, 4'd1));
        wait_done();
        pulse_reset();

        // STEP_A rpt=1: S0 -> S1 -> S0, busy two cycles.
        issue(OP_STEP_A, 4'd1, 1'b1, mk_exp(2'd0, 1'b0, 8'd0, 4'd2, 4'd2, 4'd0));
        wait_done();

        // Into S1, then RESYNC drives a=1 once back to S0; a second RESYNC drives a=b=0.
        issue(OP_STEP_A, 4'd0, 1'b1, mk_exp(2'd1, 1'b0, 8'd0, 4'd1, 4'd1, 4'd0));
        wait_done();
        issue(OP_RESYNC, 4'd0, 1'b1, mk_exp(2'd0, 1'b0, 8'd0, 4'd1, 4'd1, 4'd0));
        wait_done();
        issue(OP_RESYNC, 4'd0, 1'b1, mk_exp(2'd0, 1'b0, 8'd0, 4'd1, 4'd0, 4'd0));
        wait_done();

        // HOLD rpt=2 with y1 forced low: three mismatches, then clear.
        force_y1_low = 1'b1;
        issue(OP_HOLD, 4'd2, 1'b1, mk_exp(2'd0, 1'b1, 8'd3, 4'd3, 4'd0, 4'd0));
        wait_done();
        force_y1_low = 1'b0;
        @(posedge clk_amisha);
        #1 err_clr = 1'b1;
        @(posedge clk_amisha);
        #1 err_clr = 1'b0;
        @(negedge clk_amisha);
        check("clr_err_count", 32'(err_count), 32'd0);
        check("clr_err_flag", 32'(err_flag), 32'd0);

        // Asynchronous reset in the middle of a long STEP_A.
        issue(OP_STEP_A, 4'd7, 1'b0, '0);
        repeat (3) @(negedge clk_amisha);
        check("busy_mid_drive", 32'(cmd_ready), 32'd0);
        #2 reset_amisha = 1'b1;
        #1;
        check("midrst_a_out", 32'(a_out), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_shadow", 32'(shadow_state), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk_amisha);
        reset_amisha = 1'b0;
        repeat (12) @(negedge clk_amisha);
        check("no_done_after_rst", 32'(done), 32'd0);

        // CNT_W=2 instance: five forced mismatches saturate at 3.
        @(negedge clk_amisha);
        cmd_valid2 = 1'b1; cmd_op2 = OP_HOLD; cmd_rpt2 = 4'd4;
        @(posedge clk_amisha);
        #1 cmd_valid2 = 1'b0;
        t = 0;
        @(negedge clk_amisha);
        while (!done2 && t < 40) begin
            @(negedge clk_amisha);
            t++;
        end
        check("sat_done", 32'(done2), 32'd1);
        check("sat_err_count", 32'(err_count2), 32'd3);
        check("sat_err_flag", 32'(err_flag2), 32'd1);

        // Clear coincident with a mismatch leaves a count of 1.
        @(negedge clk_amisha);
        cmd_valid2 = 1'b1; cmd_rpt2 = 4'd0;
        @(posedge clk_amisha);
        #1 cmd_valid2 = 1'b0;
        err_clr2 = 1'b1;
        @(posedge clk_amisha);
        #1 err_clr2 = 1'b0;
        @(negedge clk_amisha);
        check("clr_mis_done", 32'(done2), 32'd1);
        check("clr_mis_count", 32'(err_count2), 32'd1);
        check("clr_mis_flag", 32'(err_flag2), 32'd1);

        repeat (4) @(negedge clk_amisha);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fsm_eg_stim_driver.md
Name: fsm_eg_stim_driver

Overview:
- Drives the a/b inputs of the two-segment example FSM and checks its y0/y1 responses.
- Holds a shadow copy of the example FSM state (S0/S1/S2), takes one-cycle stimulus commands with a repeat count, and counts response mismatches.
- Sits beside the example FSM on the same clock and reset, on the opposite side of the a/b/y interface.

Parameters:
- CNT_W, 8: width of the saturating mismatch counter.
- RPT_W, 4: width of the command repeat field.

Ports:
- clk_amisha  input  1  clock; all logic on the rising edge.
- reset_amisha  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  a command is presented.
- cmd_op  input  2  00 HOLD, 01 STEP_A, 10 STEP_AB, 11 RESYNC.
- cmd_rpt  input  RPT_W  number of drive cycles minus 1.
- cmd_ready  output  1  driver can accept a command.
- a_out  output  1  drives the FSM a input (registered).
- b_out  output  1  drives the FSM b input (registered).
- y0_in  input  1  y0 from the example FSM.
- y1_in  input  1  y1 from the example FSM.
- err_clr  input  1  clears err_flag and err_count.
- shadow_state  output  2  predicted FSM state (00 S0, 01 S1, 10 S2).
- err_flag  output  1  sticky mismatch indicator.
- err_count  output  CNT_W  saturating mismatch count.
- done  output  1  one-cycle pulse after the last drive cycle of a command.

Behaviour:
- Reset (asynchronous, mid-operation included):
  - Driver goes to IDLE.
  - a_out=0, b_out=0, cmd_ready=1, done=0.
  - shadow_state=S0, err_flag=0, err_count=0, repeat counter=0.
- Driver states are IDLE and DRIVE. cmd_ready=1 only in IDLE.
- IDLE:
  - cmd_valid && cmd_ready accepts the command at that edge.
  - The edge latches op and rpt, loads the repeat counter with cmd_rpt, sets a_out/b_out, and moves to DRIVE.
- Per-op drive values, recomputed at every drive-cycle edge from the shadow state being entered:
  - HOLD: a=0, b=0.
  - STEP_A: a=1, b=0.
  - STEP_AB: a=1, b=1.
  - RESYNC: a=1, b=0 if shadow is S1; otherwise a=0, b=0.
- DRIVE: each cycle a_out/b_out are stable. At the end-of-cycle edge:
  - Sample y0_in/y1_in and compare to expectation.
  - Advance the shadow state.
  - If counter==0: return to IDLE, pulse done for the next cycle, and drive a_out=b_out=0.
  - Otherwise: decrement the counter and stay in DRIVE.
- Latency and throughput:
  - A command with rpt=N occupies N+1 DRIVE cycles plus 1 IDLE cycle.
  - Throughput is one command per N+2 cycles.
  - done is asserted in the IDLE cycle where cmd_ready is 1 again.
- Shadow transitions, evaluated only in DRIVE with the current a/b:
  - S0: a&b -> S2; a&!b -> S1; !a -> S0.
  - S1: a -> S0; else S1.
  - S2 -> S0 unconditionally.
  - Code 11 -> S0.
- Expected responses, checked only in DRIVE:
  - exp_y1 = (shadow==S0) || (shadow==S1).
  - exp_y0 = (shadow==S0) && a_out && b_out.
  - Mismatch = (y0_in!=exp_y0) || (y1_in!=exp_y1).
- Error counter:
  - On mismatch: err_flag<=1, and err_count increments, saturating at 2^CNT_W-1.
  - err_clr alone: err_flag<=0, err_count<=0.
  - err_clr in the same cycle as a mismatch: err_flag=1, err_count=1 (clear then count).
- IDLE has no checking and no shadow update; y inputs are ignored.
- cmd_valid while cmd_ready=0 is ignored; the command is not buffered.
- RESYNC with rpt=0 returns the shadow to S0 from any state in one drive cycle.

Test Plan:
- Reset, then STEP_AB rpt=0 with the FSM attached:
  - a_out=b_out=1 for exactly 1 cycle, with y0=1, y1=1 observed.
  - Shadow S0->S2, done pulse, err_count=0.
- STEP_A rpt=1 from S0:
  - Shadow S0->S1->S0 with a_out=1, b_out=0 for 2 cycles.
  - y1=1 both cycles, err_count=0.
  - cmd_ready low for 2 cycles.
- Force y1_in=0 for 3 drive cycles of HOLD rpt=2 from S0:
  - err_count=3, err_flag=1.
  - Then pulse err_clr -> err_count=0, err_flag=0.
- CNT_W=2 with repeated forced mismatches:
  - err_count saturates at 3.
  - err_clr coincident with a mismatch gives err_count=1.
- Assert reset_amisha mid-DRIVE of STEP_A rpt=7:
  - Immediately a_out=0, cmd_ready=1, shadow S0, counters 0, no done pulse.
- From S1 (after STEP_A), RESYNC rpt=0:
  - a_out=1, b_out=0 for 1 cycle, shadow S1->S0.
  - A following RESYNC drives a=b=0 and keeps S0.
